// File: rtl/intan_spi_responder_emu.sv
//------------------------------------------------------------------------------
// Module  : intan_spi_responder_emu
// Purpose : RHD2164-style Intan SPI responder emulator (die A on cipo0, die B
//           on cipo1) with the two-frame command/result pipeline.
// Option  : INTAN_EMU_FRAME_ERR_EN adds the frame_err_cnt port.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module intan_spi_responder_emu #(
  parameter logic [7:0]  CHIP_ID     = 8'd4,
  parameter logic [15:0] DIE_B_XOR   = 16'h8000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sclk,
  input  logic       csn,
  input  logic       copi,
  output logic       cipo0,
  output logic       cipo1
`ifdef INTAN_EMU_FRAME_ERR_EN
  ,
  output logic [7:0] frame_err_cnt
`endif
);

  localparam logic [4:0] c_BITS_FULL = 5'd16;
  localparam logic [4:0] c_BITS_SAT  = 5'd17;
  localparam logic [5:0] c_REG_LAST  = 6'd17;
  localparam logic [5:0] c_SCAN_LAST = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic                   r_sclk_prev;
  logic                   r_csn_prev;

  logic [15:0] r_rx;
  logic [15:0] r_tx0;
  logic [15:0] r_tx1;
  logic [4:0]  r_bitcnt;
  logic [15:0] r_slot0_a;
  logic [15:0] r_slot0_b;
  logic [15:0] r_slot1_a;
  logic [15:0] r_slot1_b;
  logic [9:0]  r_samp;
  logic [7:0]  r_regs [0:17];

  logic        w_sclk;
  logic        w_csn;
  logic        w_copi;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_csn_rise;
  logic        w_csn_fall;
  logic        w_frame_ok;
  logic [5:0]  w_addr;
  logic [7:0]  w_rd_val;
  logic [15:0] w_res_a;
  logic [15:0] w_res_b;
  logic        w_reg_we;
  logic        w_samp_inc;

  // csn syncs to its idle-high level so reset release never fakes a falling edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sclk_sync <= '0;
      r_csn_sync  <= '1;
      r_copi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_csn_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], csn};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_csn_prev  <= r_csn_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_csn       = r_csn_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_csn_rise  = w_csn & ~r_csn_prev;
  assign w_csn_fall  = ~w_csn & r_csn_prev;
  assign w_frame_ok  = (r_bitcnt == c_BITS_FULL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_csn_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (w_csn_rise) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Command decode on the completed receive word
  assign w_addr = r_rx[13:8];

  always_comb begin
    w_rd_val = 8'h00;
    if (w_addr <= c_REG_LAST) begin
      w_rd_val = r_regs[w_addr[4:0]];
    end else begin
      case (w_addr)
        6'd40:   w_rd_val = 8'h49;
        6'd41:   w_rd_val = 8'h4E;
        6'd42:   w_rd_val = 8'h54;
        6'd43:   w_rd_val = 8'h41;
        6'd44:   w_rd_val = 8'h4E;
        6'd60:   w_rd_val = 8'd1;
        6'd61:   w_rd_val = 8'd1;
        6'd62:   w_rd_val = 8'd64;
        6'd63:   w_rd_val = CHIP_ID;
        default: w_rd_val = 8'h00;
      endcase
    end
  end

  always_comb begin
    w_res_a    = 16'h0000;
    w_res_b    = 16'h0000;
    w_reg_we   = 1'b0;
    w_samp_inc = 1'b0;
    case (r_rx[15:14])
      2'b00: begin
        w_res_a    = {w_addr, r_samp};
        w_res_b    = {w_addr, r_samp} ^ DIE_B_XOR;
        w_samp_inc = (w_addr == c_SCAN_LAST);
      end
      2'b10: begin
        w_res_a  = {8'hFF, r_rx[7:0]};
        w_res_b  = {8'hFF, r_rx[7:0]};
        w_reg_we = (w_addr <= c_REG_LAST);
      end
      2'b11: begin
        w_res_a = {8'h00, w_rd_val};
        w_res_b = {8'h00, w_rd_val};
      end
      // CALIBRATE, CLEAR and any other 01 pattern return zero with no side effect
      default: begin
        w_res_a = 16'h0000;
        w_res_b = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cipo0     <= 1'b0;
      cipo1     <= 1'b0;
      r_rx      <= 16'h0000;
      r_tx0     <= 16'h0000;
      r_tx1     <= 16'h0000;
      r_bitcnt  <= 5'd0;
      r_slot0_a <= 16'h0000;
      r_slot0_b <= 16'h0000;
      r_slot1_a <= 16'h0000;
      r_slot1_b <= 16'h0000;
      r_samp    <= 10'd0;
      for (int i = 0; i < 18; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          cipo0 <= 1'b0;
          cipo1 <= 1'b0;
          if (w_csn_fall) begin
            r_tx0    <= r_slot1_a;
            r_tx1    <= r_slot1_b;
            cipo0    <= r_slot1_a[15];
            cipo1    <= r_slot1_b[15];
            r_rx     <= 16'h0000;
            r_bitcnt <= 5'd0;
          end
        end
        ST_SHIFT: begin
          // Frame end takes priority over any sclk edge in the same cycle
          if (w_csn_rise) begin
            cipo0 <= 1'b0;
            cipo1 <= 1'b0;
          end else begin
            if (w_sclk_rise) begin
              r_rx <= {r_rx[14:0], w_copi};
              if (r_bitcnt != c_BITS_SAT) begin
                r_bitcnt <= r_bitcnt + 5'd1;
              end
            end
            if (w_sclk_fall) begin
              r_tx0 <= {r_tx0[14:0], 1'b0};
              r_tx1 <= {r_tx1[14:0], 1'b0};
              cipo0 <= r_tx0[14];
              cipo1 <= r_tx1[14];
            end
          end
        end
        ST_COMMIT: begin
          if (w_frame_ok) begin
            r_slot1_a <= r_slot0_a;
            r_slot1_b <= r_slot0_b;
            r_slot0_a <= w_res_a;
            r_slot0_b <= w_res_b;
            if (w_reg_we) begin
              r_regs[w_addr[4:0]] <= r_rx[7:0];
            end
            if (w_samp_inc) begin
              r_samp <= r_samp + 10'd1;
            end
          end
        end
        default: begin
          cipo0 <= 1'b0;
          cipo1 <= 1'b0;
        end
      endcase
    end
  end

`ifdef INTAN_EMU_FRAME_ERR_EN
  logic [7:0] r_frame_err_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_err_cnt <= 8'h00;
    end else if (r_state == ST_COMMIT && !w_frame_ok && r_frame_err_cnt != 8'hFF) begin
      r_frame_err_cnt <= r_frame_err_cnt + 8'h01;
    end
  end

  assign frame_err_cnt = r_frame_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_intan_spi_responder_emu.sv
//------------------------------------------------------------------------------
// Module  : tb_intan_spi_responder_emu
// Purpose : Self-checking bench for intan_spi_responder_emu (directed table,
//           convert scans, random frames against a queue-based model).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_intan_spi_responder_emu;

  logic clk;
  logic rstn;
  logic sclk;
  logic csn;
  logic copi;
  logic cipo0;
  logic cipo1;
`ifdef INTAN_EMU_FRAME_ERR_EN
  logic [7:0] frame_err_cnt;
`endif

  intan_spi_responder_emu dut (
    .clk   (clk),
    .rstn  (rstn),
    .sclk  (sclk),
    .csn   (csn),
    .copi  (copi),
    .cipo0 (cipo0),
`ifdef INTAN_EMU_FRAME_ERR_EN
    .cipo1 (cipo1),
    .frame_err_cnt (frame_err_cnt)
`else
    .cipo1 (cipo1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Behavioural model: results flow through a two-entry queue, front is what the next frame returns
  logic [31:0] m_q[$];
  logic [7:0]  m_regs [0:63];
  int          m_samp;
  int          m_err;
  string       c_name = "INTAN";

  task automatic model_reset();
    m_q.delete();
    m_q.push_back(32'h0);
    m_q.push_back(32'h0);
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_samp = 0;
    m_err  = 0;
  endtask

  function automatic logic [31:0] model_result(input logic [15:0] cmd);
    int          r;
    logic [15:0] a;
    logic [7:0]  v;
    r = int'(cmd[13:8]);
    a = 16'h0000;
    case (cmd[15:14])
      2'b00: begin
        a = 16'(r * 1024 + m_samp);
        if (r == 63) m_samp = (m_samp + 1) % 1024;
        return {a, a ^ 16'h8000};
      end
      2'b10: begin
        if (r <= 17) m_regs[r] = cmd[7:0];
        a = {8'hFF, cmd[7:0]};
      end
      2'b11: begin
        v = 8'h00;
        if (r <= 17) v = m_regs[r];
        else if (r >= 40 && r <= 44) v = c_name[r-40];
        else if (r == 60 || r == 61) v = 8'd1;
        else if (r == 62) v = 8'd64;
        else if (r == 63) v = 8'd4;
        a = {8'h00, v};
      end
      default: a = 16'h0000;
    endcase
    return {a, a};
  endfunction

  task automatic model_step(input logic [15:0] cmd, input int nbits);
    if (nbits == 16) begin
      void'(m_q.pop_front());
      m_q.push_back(model_result(cmd));
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One SPI frame: sclk period 10 clk, copi changes on sclk falling, cipo sampled before rising
  task automatic frame(input logic [15:0] cmd, input int nbits, input bit coinc,
                       output logic [15:0] ra, output logic [15:0] rb);
    ra = 16'h0;
    rb = 16'h0;
    csn  = 1'b0;
    copi = cmd[15];
    repeat (3) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      copi = cmd[15-i];
      repeat (5) @(negedge clk);
      ra[15-i] = cipo0;
      rb[15-i] = cipo1;
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      if (coinc && i == nbits - 1) csn = 1'b1;
    end
    if (!coinc) begin
      repeat (5) @(negedge clk);
      csn = 1'b1;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] cmd, input int nbits, input bit coinc,
                           input string name, output logic [15:0] ra, output logic [15:0] rb);
    logic [31:0] e;
    logic [15:0] mask;
    logic [15:0] all_ones;
    all_ones = 16'hFFFF;
    mask = ~(all_ones >> nbits);
    e = m_q[0];
    frame(cmd, nbits, coinc, ra, rb);
    check($sformatf("%s cmd=%h cipo0", name, cmd), ra & mask, e[31:16] & mask);
    check($sformatf("%s cmd=%h cipo1", name, cmd), rb & mask, e[15:0] & mask);
    model_step(cmd, nbits);
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t tbl[23];

  initial begin
    logic [15:0] ra, rb, cmd;
    int k;

    tbl[0]  = '{16'hE800, 16'h0000, 16'h0000};
    tbl[1]  = '{16'hE900, 16'h0000, 16'h0000};
    tbl[2]  = '{16'hEA00, 16'h0049, 16'h0049};
    tbl[3]  = '{16'hFF00, 16'h004E, 16'h004E};
    tbl[4]  = '{16'hFF00, 16'h0054, 16'h0054};
    tbl[5]  = '{16'h85A7, 16'h0004, 16'h0004};
    tbl[6]  = '{16'hC500, 16'h0004, 16'h0004};
    tbl[7]  = '{16'hFF00, 16'hFFA7, 16'hFFA7};
    tbl[8]  = '{16'hFF00, 16'h00A7, 16'h00A7};
    tbl[9]  = '{16'hD400, 16'h0004, 16'h0004};
    tbl[10] = '{16'hFF00, 16'h0004, 16'h0004};
    tbl[11] = '{16'h5500, 16'h0000, 16'h0000};
    tbl[12] = '{16'h6A00, 16'h0004, 16'h0004};
    tbl[13] = '{16'hFC00, 16'h0000, 16'h0000};
    tbl[14] = '{16'hFD00, 16'h0000, 16'h0000};
    tbl[15] = '{16'hFE00, 16'h0001, 16'h0001};
    tbl[16] = '{16'hFF00, 16'h0001, 16'h0001};
    tbl[17] = '{16'hEB00, 16'h0040, 16'h0040};
    tbl[18] = '{16'hEC00, 16'h0004, 16'h0004};
    tbl[19] = '{16'h9455, 16'h0041, 16'h0041};
    tbl[20] = '{16'hD400, 16'h004E, 16'h004E};
    tbl[21] = '{16'hFF00, 16'hFF55, 16'hFF55};
    tbl[22] = '{16'hFF00, 16'h0000, 16'h0000};

    rstn = 1'b0;
    sclk = 1'b0;
    csn  = 1'b1;
    copi = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset cipo0", {15'h0, cipo0}, 16'h0);
    check("reset cipo1", {15'h0, cipo1}, 16'h0);
`ifdef INTAN_EMU_FRAME_ERR_EN
    check("reset frame_err_cnt", {8'h0, frame_err_cnt}, 16'h0);
`endif
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      frame(tbl[i].cmd, 16, 1'b0, ra, rb);
      check($sformatf("table[%0d] cipo0", i), ra, tbl[i].exp_a);
      check($sformatf("table[%0d] cipo1", i), rb, tbl[i].exp_b);
      model_step(tbl[i].cmd, 16);
    end

    for (int s = 0; s < 2; s++) begin
      for (int ch = 0; ch < 64; ch++) begin
        run_frame({2'b00, 6'(ch), 8'h00}, 16, 1'b0, "scan", ra, rb);
        if (s == 1 && ch == 9) begin
          check("scan2 ch7 cipo0", ra, 16'h1C01);
          check("scan2 ch7 cipo1", rb, 16'h9C01);
        end
      end
    end

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      case (k)
        0: cmd = {2'b00, 6'($urandom_range(0, 63)), 8'($urandom)};
        1: cmd = {2'b10, 6'($urandom_range(0, 25)), 8'($urandom)};
        2: cmd = {2'b11, 6'($urandom_range(0, 1) != 0 ? $urandom_range(0, 20) : $urandom_range(0, 63)), 8'($urandom)};
        default: cmd = ($urandom_range(0, 2) == 0) ? 16'h5500 :
                       ($urandom_range(0, 1) == 0) ? 16'h6A00 : {2'b01, 14'($urandom)};
      endcase
      run_frame(cmd, 16, 1'b0, "random", ra, rb);
    end

    run_frame(16'hFF00, 12, 1'b0, "short12", ra, rb);
`ifdef INTAN_EMU_FRAME_ERR_EN
    check("frame_err_cnt after short", {8'h0, frame_err_cnt}, 16'(m_err));
`endif
    for (int n = 0; n < 3; n++) run_frame(16'hE900 + 16'(n * 256), 16, 1'b0, "post-short", ra, rb);

    run_frame(16'hE900, 16, 1'b1, "coincident", ra, rb);
    run_frame(16'hFF00, 16, 1'b0, "after-coinc", ra, rb);
    run_frame(16'hFF00, 16, 1'b0, "after-coinc", ra, rb);
    check("coincident READ41 result", ra, 16'h004E);

    csn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      copi = 1'($urandom);
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("midframe reset cipo0", {15'h0, cipo0}, 16'h0);
    check("midframe reset cipo1", {15'h0, cipo1}, 16'h0);
    csn = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    check("post-reset idle cipo0", {15'h0, cipo0}, 16'h0);
    for (int n = 0; n < 3; n++) run_frame(16'hFF00, 16, 1'b0, "post-reset", ra, rb);
    check("post-reset CHIP_ID", ra, 16'h0004);
`ifdef INTAN_EMU_FRAME_ERR_EN
    check("frame_err_cnt after reset", {8'h0, frame_err_cnt}, 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
